stream_mux_nto1: RTL
====================

Name: stream_mux_nto1

Overview:
- Parametrised successor to the 8-bit 2:1 select mux: N_CH input channels of WIDTH bits each, merged onto one output stream.
- Valid/ready handshake on every channel and on the output.
- Two selection modes: explicit select and round-robin.
- One registered output stage; sits between producer blocks and a single shared consumer in the datapath.

Parameters:
WIDTH, 8, data width of each channel and of the output
N_CH, 4, number of input channels (>=2)
SEL_W, $clog2(N_CH), width of sel_i and out_ch_o (derived; do not override)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
mode_i  input  1  0 = MODE_SEL (use sel_i), 1 = MODE_RR (round-robin)
sel_i  input  SEL_W  channel index used in MODE_SEL
in_data_i  input  N_CH x WIDTH  per-channel data
in_valid_i  input  N_CH  per-channel valid
in_ready_o  output  N_CH  per-channel ready; at most one bit high per cycle
out_data_o  output  WIDTH  registered output data
out_valid_o  output  1  registered output valid
out_ready_i  input  1  consumer ready
out_ch_o  output  SEL_W  index of the channel that supplied out_data_o

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - out_valid_o=0, out_data_o=0, out_ch_o=0.
  - RR pointer = N_CH-1, so channel 0 has first priority.
  - Lock state = IDLE.
  - Reset mid-transfer drops the held beat. in_ready_o is 0 during reset.
- Load enable: load = !out_valid_o || out_ready_i. The output register accepts a new beat whenever it is empty or is being drained in the same cycle. Full throughput is 1 beat/cycle.
- Grant (combinational, evaluated only when load=1):
  - MODE_SEL: grant = sel_i if in_valid_i[sel_i]=1. No grant if sel_i >= N_CH or the selected channel is not valid.
  - MODE_RR: grant = the first valid channel searching upward from pointer+1, wrapping modulo N_CH.
- in_ready_o[g] = load && granted(g). A transfer happens on channel g when in_valid_i[g] && in_ready_o[g].
- On transfer:
  - out_data_o <= in_data_i[g], out_ch_o <= g, out_valid_o <= 1.
  - In MODE_RR, pointer <= g.
  - The pointer does not update in MODE_SEL.
- No transfer and out_ready_i=1: out_valid_o <= 0. out_data_o and out_ch_o hold their last values.
- Output stall (out_valid_o=1, out_ready_i=0): all in_ready_o=0, outputs stable.
- Latency: 1 cycle from input handshake to out_valid_o.
- Mode or sel_i changes take effect at the next grant evaluation, never on a held beat.
- Data must never be duplicated or dropped. in_ready_o must not depend on in_data_i.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last_i (input, N_CH) and out_last_o (output, 1, registered, reset 0).
  - Lock FSM with states IDLE and LOCKED, plus a locked-channel register.
  - IDLE -> LOCKED on a transfer with in_last_i[g]=0; the locked channel is g.
  - In LOCKED, the grant is forced to the locked channel and ignores mode_i, sel_i and other valids.
  - LOCKED -> IDLE on a transfer with in_last_i=1.
  - A single-beat packet (last=1 in IDLE) stays in IDLE.
  - out_last_o <= in_last_i[g] on each transfer.
  - The RR pointer updates only on the last beat.
- Undefined: ports absent and no FSM. Every beat is arbitrated independently.

Decomposition:
- Package stream_mux_pkg:
  - mode_e enum (MODE_SEL=1'b0, MODE_RR=1'b1).
  - lock_state_e enum (IDLE, LOCKED).
  - Helper function for the wrap-around next-index calculation.
- Sub-module rr_arbiter, parametrised on N_CH:
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
- Pointer register, output register and lock FSM stay in stream_mux_nto1.

Test Plan:
- Reset then MODE_SEL, N_CH=4, sel_i=2, in_valid_i=4'b1111, in_data_i[2]=8'hA5, out_ready_i=1:
  - in_ready_o=4'b0100.
  - Next cycle out_valid_o=1, out_data_o=8'hA5, out_ch_o=2.
- MODE_RR, all four channels valid, out_ready_i=1 for 8 cycles -> out_ch_o sequence 0,1,2,3,0,1,2,3 at 1 beat/cycle.
- MODE_RR, only channels 1 and 3 valid -> grants alternate 1,3,1,3. in_ready_o[0] and in_ready_o[2] stay 0.
- Backpressure: out_ready_i=0 for 3 cycles with out_valid_o=1 -> out_data_o stable, in_ready_o=0. On out_ready_i=1 the next beat loads the same cycle.
- Boundaries:
  - MODE_SEL with sel_i=2 and in_valid_i[2]=0 -> no transfer, out_valid_o falls to 0 after drain.
  - rst_i asserted while out_valid_o=1 -> out_valid_o=0 on the next edge.
- With STREAM_MUX_PKT_LOCK_EN, MODE_RR:
  - ch0 sends a 3-beat packet (last on beat 3) while ch1 is valid -> out_ch_o=0,0,0, then 1.
  - out_last_o=1 only on the third beat.

Source files
------------

// File: rtl/stream_mux_nto1_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
// Shared types and helpers for the N:1 valid/ready stream multiplexer.
//   mode_e       : channel selection mode (explicit select / round-robin)
//   lock_state_e : packet-lock FSM state (used when STREAM_MUX_PKT_LOCK_EN
//                  is defined)
//   next_idx()   : wrap-around successor of a channel index
// ---------------------------------------------------------------------------
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Successor of idx modulo n. Any idx at or past n-1 wraps to 0, so an
  // out-of-range pointer still resolves to a legal starting channel.
  function automatic int unsigned next_idx(input int unsigned idx,
                                           input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at the channel
// after i_ptr and wraps modulo N_CH; the first requesting channel wins.
// Ports:
//   i_req     : request vector, one bit per channel
//   i_ptr     : index of the most recently served channel
//   o_gnt_oh  : one-hot grant (all zero when nothing requests)
//   o_gnt_idx : binary index of the granted channel (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [N_CH-1:0]  o_gnt_oh,
  output logic [SEL_W-1:0] o_gnt_idx
);

  always_comb begin
    int unsigned v_start;
    int unsigned v_rank;
    int unsigned v_best;
    int unsigned v_win;
    logic        v_found;

    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    v_start   = next_idx(32'(i_ptr), N_CH);
    v_best    = N_CH;
    v_win     = 0;
    v_found   = 1'b0;
    v_rank    = 0;

    // Rank each channel by its distance from the search start; the lowest
    // ranked requester is the round-robin winner.
    for (int i = 0; i < N_CH; i++) begin
      if (unsigned'(i) >= v_start) v_rank = unsigned'(i) - v_start;
      else                         v_rank = unsigned'(i) + N_CH - v_start;
      if (i_req[i] && (v_rank < v_best)) begin
        v_best  = v_rank;
        v_win   = unsigned'(i);
        v_found = 1'b1;
      end
    end

    for (int i = 0; i < N_CH; i++) begin
      if (v_found && (v_win == unsigned'(i))) begin
        o_gnt_oh[i] = 1'b1;
        o_gnt_idx   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// ---------------------------------------------------------------------------
// stream_mux_nto1
// Merges N_CH valid/ready input streams onto one registered output stream.
// Selection is either explicit (sel_i) or round-robin. A single output
// register gives 1-cycle latency at full 1 beat/cycle throughput.
//
// Optional macro STREAM_MUX_PKT_LOCK_EN: adds in_last_i / out_last_o and a
// packet lock so a multi-beat packet is never interleaved with another.
//
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   mode_i          : 0 = explicit select, 1 = round-robin
//   sel_i           : channel index used in explicit-select mode
//   in_data_i       : per-channel data, packed [N_CH][WIDTH]
//   in_valid_i      : per-channel valid
//   in_ready_o      : per-channel ready, at most one bit set
//   in_last_i       : per-channel end-of-packet (lock build only)
//   out_data_o      : registered output data
//   out_valid_o     : registered output valid
//   out_ready_i     : consumer ready
//   out_ch_o        : channel that supplied out_data_o
//   out_last_o      : registered end-of-packet (lock build only)
//
// Lock FSM (lock build only):
//   state  | meaning
//   IDLE   | every beat is arbitrated by mode_i / sel_i
//   LOCKED | a packet is open on r_lock_ch; only that channel is granted
// ---------------------------------------------------------------------------
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       mode_i,
  input  logic [SEL_W-1:0]           sel_i,
  input  logic [N_CH-1:0][WIDTH-1:0] in_data_i,
  input  logic [N_CH-1:0]            in_valid_i,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N_CH-1:0]            in_last_i,
  output logic                       out_last_o,
`endif
  output logic [N_CH-1:0]            in_ready_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [SEL_W-1:0]           out_ch_o
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load;
  logic             w_xfer;
  logic             w_mode_rr;
  logic [N_CH-1:0]  w_sel_oh;
  logic [N_CH-1:0]  w_rr_oh;
  logic [SEL_W-1:0] w_rr_idx;
  logic [N_CH-1:0]  w_arb_oh;
  logic [N_CH-1:0]  w_gnt_oh;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_data;

`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_state_e      r_lock_state;
  logic [SEL_W-1:0] r_lock_ch;
  logic             r_last;
  logic [N_CH-1:0]  w_lock_oh;
  logic             w_last;
`endif

  // The output register can take a beat when empty or draining this cycle.
  // Held low in reset so no producer sees a handshake that gets discarded.
  assign w_load    = (!r_valid || out_ready_i) && !rst_i;
  assign w_mode_rr = (mode_e'(mode_i) == MODE_RR);

  // Explicit select: an out-of-range sel_i matches no channel, so no grant.
  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sel_oh[i] = (sel_i == SEL_W'(i)) && in_valid_i[i];
    end
  end

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .i_req     (in_valid_i),
    .i_ptr     (r_ptr),
    .o_gnt_oh  (w_rr_oh),
    .o_gnt_idx (w_rr_idx)
  );

  assign w_arb_oh = w_mode_rr ? w_rr_oh : w_sel_oh;

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_comb begin
    w_lock_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_lock_oh[i] = (r_lock_ch == SEL_W'(i)) && in_valid_i[i];
    end
  end

  // An open packet overrides mode, select and all other requesters.
  always_comb begin
    w_gnt_oh = '0;
    if (w_load) begin
      w_gnt_oh = (r_lock_state == LOCKED) ? w_lock_oh : w_arb_oh;
    end
  end
`else
  always_comb begin
    w_gnt_oh = '0;
    if (w_load) begin
      w_gnt_oh = w_arb_oh;
    end
  end
`endif

  // Grants are only ever raised for valid channels, so any grant bit is a
  // completed handshake.
  assign in_ready_o = w_gnt_oh;
  assign w_xfer     = |w_gnt_oh;

  always_comb begin
    w_gnt_idx = '0;
    w_data    = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    w_last    = 1'b0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (w_gnt_oh[i]) begin
        w_gnt_idx = SEL_W'(i);
        w_data    = in_data_i[i];
`ifdef STREAM_MUX_PKT_LOCK_EN
        w_last    = in_last_i[i];
`endif
      end
    end
  end

  // Output register, round-robin pointer and lock FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ch         <= '0;
      r_ptr        <= SEL_W'(N_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      r_last       <= 1'b0;
      r_lock_state <= IDLE;
      r_lock_ch    <= '0;
`endif
    end else if (w_load) begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_ch    <= w_gnt_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
        r_last  <= w_last;
        // Fairness is tracked per packet, not per beat.
        if (w_mode_rr && w_last) begin
          r_ptr <= w_gnt_idx;
        end
        case (r_lock_state)
          IDLE: begin
            if (!w_last) begin
              r_lock_state <= LOCKED;
              r_lock_ch    <= w_gnt_idx;
            end
          end
          LOCKED: begin
            if (w_last) begin
              r_lock_state <= IDLE;
            end
          end
          default: r_lock_state <= IDLE;
        endcase
`else
        if (w_mode_rr) begin
          r_ptr <= w_gnt_idx;
        end
`endif
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_ch_o    = r_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign out_last_o  = r_last;
`endif

endmodule
